// File: rtl/tiny85_portb_io.sv
// ---------------------------------------------------------------------------
// tiny85_portb_io
// CPU-side Port B block for the tiny85 core. It holds DDRB, PORTB and PCMSK,
// synchronises the pad levels into PINB, drives the pad outputs and enables,
// and raises the pin-change interrupt request (PCINT0).
// A low vcc behaves exactly like rst: all state clears on the next edge, which
// turns every pad drive off and drops any read that is in flight.
// ---------------------------------------------------------------------------
module tiny85_portb_io #(
    parameter int         NPINS       = 6,
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] A_PCMSK     = 6'h15,
    parameter logic [5:0] A_PINB      = 6'h16,
    parameter logic [5:0] A_DDRB      = 6'h17,
    parameter logic [5:0] A_PORTB     = 6'h18,
    parameter logic [5:0] A_GIFR      = 6'h3A,
    parameter logic [5:0] A_GIMSK     = 6'h3B
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vcc,
    input  logic [5:0]       io_addr,
    input  logic             io_wr,
    input  logic             io_rd,
    input  logic [7:0]       io_wdata,
    output logic [7:0]       io_rdata,
    output logic             io_rvalid,
    input  logic [NPINS-1:0] pin_in,
    output logic [NPINS-1:0] pin_out,
    output logic [NPINS-1:0] pin_oe,
    output logic [NPINS-1:0] pin_pullup,
    output logic             pcint_irq
);

    // PCIE sits in GIMSK bit 5 and PCIF in GIFR bit 5.
    localparam int PC_BIT = 5;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NPINS-1:0] ddrb;
    logic [NPINS-1:0] portb;
    logic [NPINS-1:0] pcmsk;
    logic [NPINS-1:0] prev;
    logic [NPINS-1:0] sync_q [SYNC_STAGES];
    logic             pcie;
    logic             pcif;

    // Loss of supply is folded into the ordinary synchronous reset.
    logic reset_any;
    assign reset_any = rst | ~vcc;

    // PINB is the last synchroniser stage.
    logic [NPINS-1:0] pinb;
    assign pinb = sync_q[SYNC_STAGES-1];

    // Only the pin-wide slice of the write data and GIMSK/GIFR bit 5 matter.
    logic unused_wdata;
    assign unused_wdata = ^io_wdata;

    // -----------------------------------------------------------------------
    // Write decode
    // -----------------------------------------------------------------------
    logic wr_pcmsk;
    logic wr_pinb;
    logic wr_ddrb;
    logic wr_portb;
    logic wr_gifr;
    logic wr_gimsk;

    assign wr_pcmsk = io_wr && (io_addr == A_PCMSK);
    assign wr_pinb  = io_wr && (io_addr == A_PINB);
    assign wr_ddrb  = io_wr && (io_addr == A_DDRB);
    assign wr_portb = io_wr && (io_addr == A_PORTB);
    assign wr_gifr  = io_wr && (io_addr == A_GIFR);
    assign wr_gimsk = io_wr && (io_addr == A_GIMSK);

    logic [NPINS-1:0] wdata_pins;
    assign wdata_pins = io_wdata[NPINS-1:0];

    // -----------------------------------------------------------------------
    // Pin-change detection: compare the synchronised level against the
    // previous sample. prev follows every pin so unmasking a pin later does
    // not report a stale edge.
    // -----------------------------------------------------------------------
    logic [NPINS-1:0] chg;
    logic             pc_hit;

    assign chg    = (pinb ^ prev) & pcmsk;
    assign pc_hit = |chg;

    // Input synchroniser chain, one flop per pin per stage.
    always_ff @(posedge clk) begin
        // NOTE: every flop here uses <= so all stages sample the value from
        // before the edge; a blocking = would collapse the chain into one flop.
        if (reset_any) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Control registers, edge history and the pin-change flag.
    always_ff @(posedge clk) begin
        if (reset_any) begin
            ddrb  <= '0;
            portb <= '0;
            pcmsk <= '0;
            prev  <= '0;
            pcie  <= 1'b0;
            pcif  <= 1'b0;
        end else begin
            // Writing 1s to PINB toggles the matching PORTB bits.
            if (wr_portb) begin
                portb <= wdata_pins;
            end else if (wr_pinb) begin
                portb <= portb ^ wdata_pins;
            end

            if (wr_ddrb) begin
                ddrb <= wdata_pins;
            end

            if (wr_pcmsk) begin
                pcmsk <= wdata_pins;
            end

            if (wr_gimsk) begin
                pcie <= io_wdata[PC_BIT];
            end

            prev <= pinb;

            // A new edge beats a software clear in the same cycle so no
            // change is ever lost.
            if (pc_hit) begin
                pcif <= 1'b1;
            end else if (wr_gifr && io_wdata[PC_BIT]) begin
                pcif <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    logic [7:0] rd_mux;

    // Select the register image addressed by io_addr; bits above the pin
    // count and unmapped addresses return 0.
    always_comb begin
        // NOTE: the default assignment up front keeps this purely
        // combinational; leaving rd_mux unassigned on some path infers a latch.
        rd_mux = 8'h00;
        case (io_addr)
            A_PCMSK: rd_mux = 8'(pcmsk);
            A_PINB:  rd_mux = 8'(pinb);
            A_DDRB:  rd_mux = 8'(ddrb);
            A_PORTB: rd_mux = 8'(portb);
            A_GIFR:  rd_mux = {2'b00, pcif, 5'b0_0000};
            A_GIMSK: rd_mux = {2'b00, pcie, 5'b0_0000};
            default: rd_mux = 8'h00;
        endcase
    end

    // Register read data one cycle after the strobe; reset drops it.
    always_ff @(posedge clk) begin
        if (reset_any) begin
            io_rvalid <= 1'b0;
            io_rdata  <= 8'h00;
        end else begin
            io_rvalid <= io_rd;
            io_rdata  <= io_rd ? rd_mux : 8'h00;
        end
    end

    // -----------------------------------------------------------------------
    // Pad-side outputs. The pad ring applies pin_oe, so pin_out simply
    // mirrors PORTB whatever the direction.
    // -----------------------------------------------------------------------
    assign pin_out    = portb;
    assign pin_oe     = ddrb;
    assign pin_pullup = portb & ~ddrb;
    assign pcint_irq  = pcif & pcie;

endmodule

// File: tb/tb_tiny85_portb_io.sv
// ---------------------------------------------------------------------------
// tb_tiny85_portb_io
// Directed bench for tiny85_portb_io. Expected read data is queued when a read
// is issued and compared when io_rvalid appears; pad outputs and the interrupt
// are compared against constants derived by hand.
// ---------------------------------------------------------------------------
module tb_tiny85_portb_io;

    localparam int         NPINS   = 6;
    localparam logic [5:0] A_PCMSK = 6'h15;
    localparam logic [5:0] A_PINB  = 6'h16;
    localparam logic [5:0] A_DDRB  = 6'h17;
    localparam logic [5:0] A_PORTB = 6'h18;
    localparam logic [5:0] A_GIFR  = 6'h3A;
    localparam logic [5:0] A_GIMSK = 6'h3B;
    localparam logic [5:0] A_UNMAP = 6'h20;

    logic             clk;
    logic             rst;
    logic             vcc;
    logic [5:0]       io_addr;
    logic             io_wr;
    logic             io_rd;
    logic [7:0]       io_wdata;
    logic [7:0]       io_rdata;
    logic             io_rvalid;
    logic [NPINS-1:0] pin_in;
    logic [NPINS-1:0] pin_out;
    logic [NPINS-1:0] pin_oe;
    logic [NPINS-1:0] pin_pullup;
    logic             pcint_irq;

    int n_checks;
    int n_errors;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t sb [$];

    tiny85_portb_io #(.NPINS(NPINS), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .vcc        (vcc),
        .io_addr    (io_addr),
        .io_wr      (io_wr),
        .io_rd      (io_rd),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_rvalid  (io_rvalid),
        .pin_in     (pin_in),
        .pin_out    (pin_out),
        .pin_oe     (pin_oe),
        .pin_pullup (pin_pullup),
        .pcint_irq  (pcint_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample strobes before the edge, then check io_rvalid and
    // drain the scoreboard 1 ns after the edge.
    task automatic step();
        logic rd_issued;
        logic in_reset;
        sb_entry_t e;
        rd_issued = io_rd;
        in_reset  = rst || !vcc;
        @(posedge clk);
        #1;
        check("rvalid", 32'(io_rvalid), 32'(rd_issued && !in_reset));
        if (io_rvalid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL sb_underflow: observed=rvalid expected=no_read_pending");
            end else begin
                e = sb.pop_front();
                check(e.tag, 32'(io_rdata), 32'(e.exp));
            end
        end
    endtask

    task automatic wr(input logic [5:0] addr, input logic [7:0] data);
        io_addr  = addr;
        io_wdata = data;
        io_wr    = 1'b1;
        step();
        io_wr    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [5:0] addr, input logic [7:0] exp);
        sb.push_back('{tag: tag, exp: exp});
        io_addr = addr;
        io_rd   = 1'b1;
        step();
        io_rd   = 1'b0;
    endtask

    initial begin
        int kind;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        vcc      = 1'b1;
        io_addr  = '0;
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        io_wdata = '0;
        pin_in   = '0;

        // ---------------- Reset with random bus traffic ----------------
        for (int i = 0; i < 2; i++) begin
            kind     = int'($urandom_range(0, 2));
            io_addr  = 6'($urandom_range(0, 63));
            io_wdata = 8'($urandom);
            io_wr    = (kind == 1);
            io_rd    = (kind == 2);
            step();
        end
        io_wr = 1'b0;
        io_rd = 1'b0;
        rst   = 1'b0;
        check("rst_pin_out", 32'(pin_out), 32'h0);
        check("rst_pin_oe", 32'(pin_oe), 32'h0);
        check("rst_pullup", 32'(pin_pullup), 32'h0);
        check("rst_irq", 32'(pcint_irq), 32'h0);
        rd("rst_pcmsk", A_PCMSK, 8'h00);
        rd("rst_pinb", A_PINB, 8'h00);
        rd("rst_ddrb", A_DDRB, 8'h00);
        rd("rst_portb", A_PORTB, 8'h00);
        rd("rst_gifr", A_GIFR, 8'h00);
        rd("rst_gimsk", A_GIMSK, 8'h00);

        // ---------------- Output path ----------------
        wr(A_DDRB, 8'h03);
        wr(A_PORTB, 8'h01);
        check("out_oe", 32'(pin_oe), 32'h03);
        check("out_val", 32'(pin_out), 32'h01);
        check("out_pullup0", 32'(pin_pullup), 32'h00);
        wr(A_PINB, 8'h03);
        check("pinb_toggle", 32'(pin_out), 32'h02);
        wr(A_PORTB, 8'h3C);
        check("pullup_3c", 32'(pin_pullup), 32'h3C);
        check("out_3c", 32'(pin_out), 32'h3C);
        rd("rd_portb", A_PORTB, 8'h3C);
        rd("rd_ddrb", A_DDRB, 8'h03);

        // ---------------- Input synchroniser ----------------
        pin_in = 6'h14;
        step();                          // edge N samples the new level
        rd("sync_n1", A_PINB, 8'h00);    // read at N+1: not yet through
        rd("sync_n2", A_PINB, 8'h14);    // read at N+2: visible

        // ---------------- Pin-change interrupt ----------------
        wr(A_PCMSK, 8'h04);
        wr(A_GIMSK, 8'h20);
        rd("rd_gimsk", A_GIMSK, 8'h20);
        pin_in = 6'h1C;                  // PB3 toggles, not masked
        for (int i = 0; i < 4; i++) step();
        check("pb3_no_irq", 32'(pcint_irq), 32'h0);
        rd("pb3_gifr", A_GIFR, 8'h00);

        pin_in = 6'h18;                  // PB2 toggles, masked in
        step();                          // N: sync stage 0
        check("pb2_n", 32'(pcint_irq), 32'h0);
        step();                          // N+1: reaches PINB
        check("pb2_n1", 32'(pcint_irq), 32'h0);
        step();                          // N+2: edge detected
        check("pb2_irq", 32'(pcint_irq), 32'h1);
        rd("pb2_gifr", A_GIFR, 8'h20);
        wr(A_GIFR, 8'h20);
        check("gifr_clear", 32'(pcint_irq), 32'h0);

        pin_in = 6'h1C;                  // set PCIF again
        for (int i = 0; i < 3; i++) step();
        check("pb2_irq2", 32'(pcint_irq), 32'h1);
        wr(A_GIFR, 8'h00);
        check("gifr_zero_noop", 32'(pcint_irq), 32'h1);

        pin_in = 6'h18;                  // detection lands on the clear edge
        step();
        step();
        wr(A_GIFR, 8'h20);
        check("set_wins", 32'(pcint_irq), 32'h1);
        rd("set_wins_gifr", A_GIFR, 8'h20);
        wr(A_GIFR, 8'h20);
        check("final_clear", 32'(pcint_irq), 32'h0);

        // ---------------- Power loss ----------------
        wr(A_DDRB, 8'h3F);
        wr(A_PORTB, 8'h2A);
        check("pwr_out_pre", 32'(pin_out), 32'h2A);
        check("pwr_oe_pre", 32'(pin_oe), 32'h3F);
        vcc     = 1'b0;
        io_addr = A_PORTB;
        io_rd   = 1'b1;                  // dropped: no rvalid expected
        step();
        io_rd   = 1'b0;
        vcc     = 1'b1;
        check("pwr_out", 32'(pin_out), 32'h00);
        check("pwr_oe", 32'(pin_oe), 32'h00);
        step();
        rd("pwr_ddrb", A_DDRB, 8'h00);
        rd("pwr_portb", A_PORTB, 8'h00);
        rd("pwr_pcmsk", A_PCMSK, 8'h00);
        rd("pwr_gimsk", A_GIMSK, 8'h00);

        // ---------------- Unmapped address ----------------
        wr(A_DDRB, 8'h05);
        wr(A_UNMAP, 8'hFF);
        rd("unmap_rd", A_UNMAP, 8'h00);
        rd("unmap_ddrb", A_DDRB, 8'h05);
        rd("unmap_portb", A_PORTB, 8'h00);
        rd("unmap_pcmsk", A_PCMSK, 8'h00);
        rd("unmap_gimsk", A_GIMSK, 8'h00);
        check("unmap_oe", 32'(pin_oe), 32'h05);
        check("unmap_out", 32'(pin_out), 32'h00);

        step();
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
